mod_count_checker: RTL and testbench

MOD_COUNT_CHECKER -- requirements
Module: mod_count_checker

---
 rtl/mod_count_checker.sv | 138 +++++++++++++
 tb/tb_mod_count_checker.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mod_count_checker.sv
// Checks the sample stream of a mod-N up/down counter against the configured modulus and direction.
// Tracks lock, step/range errors and wraps. Every output is registered.
module mod_count_checker #(
  parameter int W        = 3,
  parameter int LOCK_RUN = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cnt_valid,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] n_cfg,
  input  logic         ud_cfg,
  output logic [W-1:0] exp_cnt,
  output logic         match,
  output logic         err,
  output logic         wrap,
  output logic         locked,
  output logic         cfg_err,
  output logic [7:0]   err_cnt,
  output logic [7:0]   wrap_cnt
);

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);
  localparam logic [3:0]   LR  = 4'(LOCK_RUN);

  state_t       state_q, state_d;
  logic [W-1:0] n_q, n_d, p_q, p_d, exp_q, exp_d;
  logic         ud_q, ud_d;
  logic [3:0]   run_q, run_d;
  logic         match_q, match_d, err_q, err_d, wrap_q, wrap_d;
  logic         locked_q, locked_d, cfg_err_q, cfg_err_d;
  logic [7:0]   err_cnt_q, err_cnt_d, wrap_cnt_q, wrap_cnt_d;
  logic [W-1:0] pred;
  logic         cfg_chg, in_range;
  logic [7:0]   err_inc;

  // Down counters may sit at N (their reset value) and step from there to N-1.
  function automatic logic [W-1:0] predict(input logic [W-1:0] p, input logic [W-1:0] n,
                                           input logic ud);
    if (ud)                    return (p == n - ONE) ? '0 : p + ONE;
    else if (p == n || p == '0) return n - ONE;
    else                       return p - ONE;
  endfunction

  always_comb begin
    n_d        = n_cfg;
    ud_d       = ud_cfg;
    state_d    = state_q;
    p_d        = p_q;
    run_d      = run_q;
    match_d    = 1'b0;
    err_d      = 1'b0;
    wrap_d     = 1'b0;
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    pred       = predict(p_q, n_q, ud_q);
    cfg_chg    = (n_cfg != n_q) || (ud_cfg != ud_q);
    in_range   = (cnt < n_q) || (!ud_q && cnt == n_q);
    err_inc    = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // A config edge or an invalid modulus discards the sample without any pulse.
    if (cfg_chg || n_q < TWO) begin
      state_d = IDLE;
    end else if (cnt_valid) begin
      if (!in_range) begin
        err_d     = 1'b1;
        err_cnt_d = err_inc;
        state_d   = IDLE;
      end else if (state_q == IDLE) begin
        p_d     = cnt;
        run_d   = '0;
        state_d = HUNT;
      end else if (cnt == pred) begin
        match_d = 1'b1;
        p_d     = cnt;
        run_d   = (run_q >= LR) ? LR : run_q + 4'd1;
        if (run_d == LR) state_d = LOCKED;
        wrap_d  = ud_q ? (p_q == n_q - ONE) : (p_q == '0);
        if (wrap_d) wrap_cnt_d = wrap_cnt_q + 8'd1;
      end else begin
        err_d     = 1'b1;
        err_cnt_d = err_inc;
        p_d       = cnt;
        run_d     = '0;
        state_d   = HUNT;
      end
    end

    exp_d     = (state_d != IDLE) ? predict(p_d, n_d, ud_d) : '0;
    locked_d  = (state_d == LOCKED);
    cfg_err_d = (n_d < TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= n_cfg;
      ud_q       <= ud_cfg;
      p_q        <= '0;
      run_q      <= '0;
      exp_q      <= '0;
      match_q    <= 1'b0;
      err_q      <= 1'b0;
      wrap_q     <= 1'b0;
      locked_q   <= 1'b0;
      cfg_err_q  <= (n_cfg < TWO);
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      ud_q       <= ud_d;
      p_q        <= p_d;
      run_q      <= run_d;
      exp_q      <= exp_d;
      match_q    <= match_d;
      err_q      <= err_d;
      wrap_q     <= wrap_d;
      locked_q   <= locked_d;
      cfg_err_q  <= cfg_err_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign exp_cnt  = exp_q;
  assign match    = match_q;
  assign err      = err_q;
  assign wrap     = wrap_q;
  assign locked   = locked_q;
  assign cfg_err  = cfg_err_q;
  assign err_cnt  = err_cnt_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_mod_count_checker.sv
// Directed vector table for mod_count_checker (W=3, LOCK_RUN=4) plus an err_cnt saturation run.
module tb_mod_count_checker;

  logic       clk = 1'b0;
  logic       reset, cnt_valid, ud_cfg;
  logic [2:0] cnt, n_cfg, exp_cnt;
  logic       match, err, wrap, locked, cfg_err;
  logic [7:0] err_cnt, wrap_cnt;

  int checks = 0;
  int errors = 0;

  mod_count_checker #(.W(3), .LOCK_RUN(4)) dut (
    .clk(clk), .reset(reset), .cnt_valid(cnt_valid), .cnt(cnt), .n_cfg(n_cfg),
    .ud_cfg(ud_cfg), .exp_cnt(exp_cnt), .match(match), .err(err), .wrap(wrap),
    .locked(locked), .cfg_err(cfg_err), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, vld;
    logic [2:0] c, n;
    logic       ud;
    logic       m, e, w, l, cf;
    logic [2:0] ex;
    logic [7:0] ec, wc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, vld, input logic [2:0] c, n, input logic ud,
                     input logic m, e, w, l, cf, input logic [2:0] ex,
                     input logic [7:0] ec, wc);
    vec_t v;
    v.rst = rst; v.vld = vld; v.c = c; v.n = n; v.ud = ud;
    v.m = m; v.e = e; v.w = w; v.l = l; v.cf = cf; v.ex = ex; v.ec = ec; v.wc = wc;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0d: got %0d expected %0d", name, idx, got, want);
    end
  endtask

  task automatic step(input logic rst, vld, input logic [2:0] c, n, input logic ud);
    reset = rst; cnt_valid = vld; cnt = c; n_cfg = n; ud_cfg = ud;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cnt_valid = 1'b0; cnt = '0; n_cfg = 3'd5; ud_cfg = 1'b1;

    //   rst vld cnt n  ud   m  e  w  l  cf ex  ec wc
    // up count n=5
    add(1, 0, 0, 5, 1,   0, 0, 0, 0, 0, 0,  0, 0);
    add(0, 1, 0, 5, 1,   0, 0, 0, 0, 0, 1,  0, 0);
    add(0, 1, 1, 5, 1,   1, 0, 0, 0, 0, 2,  0, 0);
    add(0, 1, 2, 5, 1,   1, 0, 0, 0, 0, 3,  0, 0);
    add(0, 1, 3, 5, 1,   1, 0, 0, 0, 0, 4,  0, 0);
    add(0, 1, 4, 5, 1,   1, 0, 0, 1, 0, 0,  0, 0);
    add(0, 1, 0, 5, 1,   1, 0, 1, 1, 0, 1,  0, 1);
    add(0, 1, 1, 5, 1,   1, 0, 0, 1, 0, 2,  0, 1);
    add(0, 0, 3, 5, 1,   0, 0, 0, 1, 0, 2,  0, 1);
    // down count from reset value n=5
    add(0, 0, 0, 5, 0,   0, 0, 0, 0, 0, 0,  0, 1);
    add(0, 1, 5, 5, 0,   0, 0, 0, 0, 0, 4,  0, 1);
    add(0, 1, 4, 5, 0,   1, 0, 0, 0, 0, 3,  0, 1);
    add(0, 1, 3, 5, 0,   1, 0, 0, 0, 0, 2,  0, 1);
    add(0, 1, 2, 5, 0,   1, 0, 0, 0, 0, 1,  0, 1);
    add(0, 1, 1, 5, 0,   1, 0, 0, 1, 0, 0,  0, 1);
    add(0, 1, 0, 5, 0,   1, 0, 0, 1, 0, 4,  0, 1);
    add(0, 1, 4, 5, 0,   1, 0, 1, 1, 0, 3,  0, 2);
    // reset with a valid mismatching sample while locked
    add(1, 1, 7, 5, 0,   0, 0, 0, 0, 0, 0,  0, 0);
    // step error while locked, up n=6
    add(0, 0, 0, 6, 1,   0, 0, 0, 0, 0, 0,  0, 0);
    add(0, 1, 0, 6, 1,   0, 0, 0, 0, 0, 1,  0, 0);
    add(0, 1, 1, 6, 1,   1, 0, 0, 0, 0, 2,  0, 0);
    add(0, 1, 2, 6, 1,   1, 0, 0, 0, 0, 3,  0, 0);
    add(0, 1, 3, 6, 1,   1, 0, 0, 0, 0, 4,  0, 0);
    add(0, 1, 4, 6, 1,   1, 0, 0, 1, 0, 5,  0, 0);
    add(0, 1, 5, 6, 1,   1, 0, 0, 1, 0, 0,  0, 0);
    add(0, 1, 0, 6, 1,   1, 0, 1, 1, 0, 1,  0, 1);
    add(0, 1, 1, 6, 1,   1, 0, 0, 1, 0, 2,  0, 1);
    add(0, 1, 3, 6, 1,   0, 1, 0, 0, 0, 4,  1, 1);
    add(0, 1, 4, 6, 1,   1, 0, 0, 0, 0, 5,  1, 1);
    // config change with a valid sample, then range errors, up n=4
    add(0, 1, 5, 4, 1,   0, 0, 0, 0, 0, 0,  1, 1);
    add(0, 1, 0, 4, 1,   0, 0, 0, 0, 0, 1,  1, 1);
    add(0, 1, 6, 4, 1,   0, 1, 0, 0, 0, 0,  2, 1);
    add(0, 1, 4, 4, 1,   0, 1, 0, 0, 0, 0,  3, 1);
    // invalid modulus
    add(0, 0, 0, 1, 1,   0, 0, 0, 0, 1, 0,  3, 1);
    add(0, 1, 0, 1, 1,   0, 0, 0, 0, 1, 0,  3, 1);
    add(0, 1, 1, 1, 1,   0, 0, 0, 0, 1, 0,  3, 1);
    add(0, 1, 0, 3, 1,   0, 0, 0, 0, 0, 0,  3, 1);
    add(0, 1, 0, 3, 1,   0, 0, 0, 0, 0, 1,  3, 1);
    add(0, 1, 3, 3, 1,   0, 1, 0, 0, 0, 0,  4, 1);
    // down n=3: reset value accepted, resync, wrap 0->2
    add(0, 1, 3, 3, 0,   0, 0, 0, 0, 0, 0,  4, 1);
    add(0, 1, 3, 3, 0,   0, 0, 0, 0, 0, 2,  4, 1);
    add(0, 1, 1, 3, 0,   0, 1, 0, 0, 0, 0,  5, 1);
    add(0, 1, 0, 3, 0,   1, 0, 0, 0, 0, 2,  5, 1);
    add(0, 1, 2, 3, 0,   1, 0, 1, 0, 0, 1,  5, 2);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].vld, vq[i].c, vq[i].n, vq[i].ud);
      chk("match",    i, {7'd0, match},   {7'd0, vq[i].m});
      chk("err",      i, {7'd0, err},     {7'd0, vq[i].e});
      chk("wrap",     i, {7'd0, wrap},    {7'd0, vq[i].w});
      chk("locked",   i, {7'd0, locked},  {7'd0, vq[i].l});
      chk("cfg_err",  i, {7'd0, cfg_err}, {7'd0, vq[i].cf});
      chk("exp_cnt",  i, {5'd0, exp_cnt}, {5'd0, vq[i].ex});
      chk("err_cnt",  i, err_cnt,         vq[i].ec);
      chk("wrap_cnt", i, wrap_cnt,        vq[i].wc);
    end

    // err_cnt saturation: 300 out-of-range samples in IDLE
    step(1, 0, 0, 4, 1);
    chk("sat_reset", 0, err_cnt, 8'd0);
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 7, 4, 1);
      if (i == 0)   chk("sat_first", i, err_cnt, 8'd1);
      if (i == 253) chk("sat_254",   i, err_cnt, 8'd254);
      if (i == 254) chk("sat_255",   i, err_cnt, 8'd255);
      if (i == 299) begin
        chk("sat_300", i, err_cnt, 8'd255);
        chk("sat_err", i, {7'd0, err}, 8'd1);
      end
    end
    step(0, 0, 7, 4, 1);
    chk("sat_idle_err", 0, {7'd0, err}, 8'd0);
    chk("sat_hold",     0, err_cnt,     8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // match/err exclusivity and wrap implying match, sampled away from the edge
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (match && err) begin
        errors++;
        $display("FAIL excl: match=%0d err=%0d both set", match, err);
      end
      if (wrap && !match) begin
        errors++;
        $display("FAIL wrap_imp: wrap=%0d match=%0d", wrap, match);
      end
    end
  end

endmodule
